// File: rtl/ad9238_capture.sv
// ad9238_capture: dual-channel ADC capture engine.
// Both 12-bit channels are registered every clock and written into a circular
// record buffer. After a fixed pre-trigger fill the engine arms, waits for a
// channel 1 rising crossing of trig_level (or a forced trigger), fills the
// post-trigger part of the record, then freezes the buffer and streams the
// whole record out over a valid/ready interface, oldest sample first.

module ad9238_capture #(
   parameter int DATA_W   = 12,
   parameter int ADDR_W   = 10,
   parameter int PRE_TRIG = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     adc1_data,
   input  logic [DATA_W-1:0]     adc2_data,
   input  logic                  start,
   input  logic                  force_trig,
   input  logic [DATA_W-1:0]     trig_level,
   output logic                  busy,
   output logic                  armed,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [2*DATA_W-1:0]   m_data,
   output logic                  m_last
);

   localparam int DEPTH = 1 << ADDR_W;

   // Counter and pointer constants, all at buffer-address width so the
   // pointer arithmetic wraps naturally modulo DEPTH.
   localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PRE_TRIG_A = ADDR_W'(PRE_TRIG);
   localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
   localparam logic [ADDR_W-1:0] POST_CNT  = ADDR_W'(DEPTH - PRE_TRIG - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE_FILL,
      ST_ARMED,
      ST_POST,
      ST_READ
   } state_t;

   // Input stage
   logic [DATA_W-1:0] s_cur1_q;
   logic [DATA_W-1:0] s_cur2_q;
   logic [DATA_W-1:0] s_prev_q;

   // Control state
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
   logic              m_valid_q, m_valid_d;
   logic              busy_q, busy_d;

   // Buffer and its registered read port
   logic [2*DATA_W-1:0] mem [DEPTH];
   logic [2*DATA_W-1:0] rd_data_q;
   logic                wr_en;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic                trig_hit;

   // A trigger is a forced request or channel 1 crossing the level upward
   // between the previous and current registered samples.
   assign trig_hit = force_trig | ((s_prev_q < trig_level) & (s_cur1_q >= trig_level));

   // Register both channels once and keep the previous channel 1 sample for
   // the edge detector; this runs every cycle regardless of state.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_cur1_q <= '0;
         s_cur2_q <= '0;
         s_prev_q <= '0;
      end else begin
         s_cur1_q <= adc1_data;
         s_cur2_q <= adc2_data;
         s_prev_q <= s_cur1_q;
      end
   end

   // Capture/readout sequencer: state, pointers, counters and handshake flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         trig_addr_q <= '0;
         rd_ptr_q    <= '0;
         rd_cnt_q    <= '0;
         m_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         trig_addr_q <= trig_addr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_cnt_q    <= rd_cnt_d;
         m_valid_q   <= m_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state logic. During READ the output register always holds the
   // sample at rd_ptr_q; a handshake fetches rd_ptr_q+1 in the same cycle so
   // a continuously ready sink sees one sample per clock.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      trig_addr_d = trig_addr_q;
      rd_ptr_d    = rd_ptr_q;
      rd_cnt_d    = rd_cnt_q;
      m_valid_d   = m_valid_q;
      busy_d      = busy_q;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      rd_addr     = rd_ptr_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_PRE_FILL;
               wr_ptr_d = '0;
               count_d  = '0;
               busy_d   = 1'b1;
            end
         end

         ST_PRE_FILL: begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE_A;
            if (count_q == PRE_LAST) begin
               state_d = ST_ARMED;
            end else begin
               count_d = count_q + ONE_A;
            end
         end

         ST_ARMED: begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE_A;
            if (trig_hit) begin
               trig_addr_d = wr_ptr_q;
               count_d     = POST_CNT;
               state_d     = ST_POST;
            end
         end

         ST_POST: begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE_A;
            count_d  = count_q - ONE_A;
            if (count_q == ONE_A) begin
               state_d   = ST_READ;
               rd_ptr_d  = trig_addr_q - PRE_TRIG_A;
               rd_cnt_d  = '0;
               m_valid_d = 1'b0;
            end
         end

         ST_READ: begin
            if (!m_valid_q) begin
               rd_en     = 1'b1;
               rd_addr   = rd_ptr_q;
               m_valid_d = 1'b1;
            end else if (m_ready) begin
               if (rd_cnt_q == LAST_IDX) begin
                  m_valid_d = 1'b0;
                  busy_d    = 1'b0;
                  state_d   = ST_IDLE;
               end else begin
                  rd_en    = 1'b1;
                  rd_addr  = rd_ptr_q + ONE_A;
                  rd_ptr_d = rd_ptr_q + ONE_A;
                  rd_cnt_d = rd_cnt_q + ONE_A;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Record buffer write port; contents are not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= {s_cur2_q, s_cur1_q};
      end
   end

   // Registered read port doubling as the stream output register; it only
   // loads on a fetch so data holds steady under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign busy    = busy_q;
   assign armed   = (state_q == ST_ARMED);
   assign m_valid = m_valid_q;
   assign m_data  = rd_data_q;
   assign m_last  = m_valid_q & (rd_cnt_q == LAST_IDX);

endmodule

// File: doc/ad9238_capture.md
# ad9238_capture

Dual-channel ADC capture engine: the receive-side counterpart of the dual-DAC sine output path. It samples two 12-bit ADC channels every clock, stores them in a circular buffer with a programmable pre-trigger depth, arms on a level-crossing or forced trigger, and streams the frozen record out over a valid/ready interface. It sits between the ADC module pins (data already on the sample clock domain) and downstream display or host logic.

## Interface
- DATA_W, 12: ADC sample width per channel, unsigned offset-binary.
- ADDR_W, 10: buffer address width; record depth DEPTH = 2^ADDR_W samples per channel.
- PRE_TRIG, 256: samples kept before the trigger sample; legal range 1..DEPTH-2.
- clk  in  1  sample clock, same clock driven to the ADC; one clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- adc1_data  in  DATA_W  channel 1 sample, valid every cycle.
- adc2_data  in  DATA_W  channel 2 sample, valid every cycle.
- start  in  1  one-cycle pulse; begins a capture when idle.
- force_trig  in  1  trigger immediately when armed.
- trig_level  in  DATA_W  channel 1 rising-edge threshold, unsigned.
- busy  out  1  high from accepted start until last sample accepted.
- armed  out  1  high while in ARMED.
- m_valid  out  1  readout sample valid.
- m_ready  in  1  downstream accept.
- m_data  out  2*DATA_W  {ch2, ch1} sample.
- m_last  out  1  high with the final (DEPTH-th) readout sample.

## Operation
- Input stage: adc1_data/adc2_data registered once (s_cur); previous ch1 sample kept in s_prev, updated every cycle regardless of state.
- States: IDLE, PRE_FILL, ARMED, POST, READ.
- IDLE: no writes. start=1 -> PRE_FILL, wr_ptr <= 0, count <= 0, busy <= 1. start while busy ignored.
- PRE_FILL: write s_cur to buffer[wr_ptr] every cycle, wr_ptr increments; after PRE_TRIG writes -> ARMED. Triggers ignored.
- ARMED: write every cycle, wr_ptr wraps mod DEPTH. Trigger = force_trig OR (s_prev < trig_level AND s_cur >= trig_level), both unsigned. The triggering sample is written that cycle at trig_addr; -> POST with count <= DEPTH-PRE_TRIG-1.
- POST: write count more samples, then -> READ with rd_ptr <= (trig_addr - PRE_TRIG) mod DEPTH (ADDR_W-bit wrap arithmetic).
- READ: stream DEPTH samples starting at rd_ptr, incrementing with wrap. Sample index PRE_TRIG in the stream is the trigger sample. m_last on index DEPTH-1; handshake on that sample -> IDLE, busy <= 0.
- Trigger coinciding with the final PRE_FILL write is ignored (not yet armed).
- start during READ ignored; the record is never overwritten until readout completes.

## Timing
- Reset values: busy=0, armed=0, m_valid=0, m_last=0, m_data=0; state IDLE; pointers 0. Reset mid-capture or mid-readout aborts immediately; buffer contents undefined afterward.
- Input-to-buffer latency: 1 cycle (sample at pin in cycle n written in cycle n+1).
- start accepted in cycle n -> first PRE_FILL write in cycle n+1; armed=1 from cycle n+1+PRE_TRIG.
- Trigger detected in cycle t -> armed=0 at t+1; last POST write at t+DEPTH-PRE_TRIG-1.
- Buffer read latency 1 cycle; first m_valid no more than 3 cycles after entering READ.
- Handshake: transfer when m_valid & m_ready. While m_valid=1 and m_ready=0, m_data/m_last hold stable. With m_ready held high, one sample per cycle, no bubbles after the first.
- m_valid never asserted outside READ.

## Test plan
- Ramp trigger: ADDR_W=4, PRE_TRIG=4, trig_level=100, ch1 = 0,10,20,... per cycle from start, ch2 = 4095-ch1, m_ready=1 -> 16 samples, ch1 = 60,70,...,210, trigger sample 100 at index 4, m_last only on 210, ch2 complementary.
- Forced trigger: constant ch1=50, trig_level=4000, force_trig pulsed 10 cycles after armed rises -> exactly 16 samples, busy falls after last handshake.
- Backpressure: as test 1, m_ready random 30% duty -> identical ordered stream, m_data stable whenever m_valid & !m_ready.
- Wrap: ARMED held 37 cycles before crossing -> readout still contiguous ending 11 samples after trigger; rd_ptr wrap correct.
- No-trigger edge cases: ch1 already at 200 when armed (no rising crossing), start re-pulsed while busy -> stays ARMED, armed=1, no m_valid, second start ignored.
- Reset mid-READ after 5 samples -> next cycle m_valid=0, busy=0; new start produces a full, correct 16-sample record.
